// File: rtl/obstacle_spawner_if.sv
// ---------------------------------------------------------------------------
// obstacle_spawner_if
// Bundles the game-control inputs and the obstacle-pool outputs of the
// obstacle spawner so the game top level and the spawner share one port.
//
// Signals:
//   enable       game running; low holds the spawner idle
//   tick         one-cycle frame-tick pulse
//   rand_in      random byte from the LFSR stage (used on tick cycles)
//   obs_valid    bit i = slot i holds a live obstacle
//   obs_lane     slot i lane at [2i+1:2i]
//   obs_row      slot i row at [ROW_W*i+ROW_W-1:ROW_W*i]
//   spawn_pulse  one cycle, a spawn succeeded
//   spawn_drop   one cycle, a spawn attempt found no free slot
//   passed_count obstacles that left the road on the last tick
//
// Modports:
//   master  game/controller side (drives controls, observes obstacles)
//   slave   spawner side
// ---------------------------------------------------------------------------
interface obstacle_spawner_if #(
    parameter int NUM_SLOTS = 4,
    parameter int ROW_W     = 4
);
    logic                       enable;
    logic                       tick;
    logic [7:0]                 rand_in;
    logic [NUM_SLOTS-1:0]       obs_valid;
    logic [2*NUM_SLOTS-1:0]     obs_lane;
    logic [ROW_W*NUM_SLOTS-1:0] obs_row;
    logic                       spawn_pulse;
    logic                       spawn_drop;
    logic [3:0]                 passed_count;

    modport master (
        output enable,
        output tick,
        output rand_in,
        input  obs_valid,
        input  obs_lane,
        input  obs_row,
        input  spawn_pulse,
        input  spawn_drop,
        input  passed_count
    );

    modport slave (
        input  enable,
        input  tick,
        input  rand_in,
        output obs_valid,
        output obs_lane,
        output obs_row,
        output spawn_pulse,
        output spawn_drop,
        output passed_count
    );
endinterface

// File: rtl/obstacle_spawner.sv
// ---------------------------------------------------------------------------
// obstacle_spawner
// Turns the LFSR random byte into falling obstacles. A fixed pool of slots
// is advanced one row per frame tick; every SPAWN_PERIOD ticks a new obstacle
// is placed in the lowest free slot, in a lane picked from the random byte
// that never repeats the previous spawn's lane.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   spawnBus  obstacle_spawner_if.slave: enable/tick/rand_in in,
//             slot positions and event pulses out (all registered)
// ---------------------------------------------------------------------------
module obstacle_spawner #(
    parameter int NUM_SLOTS    = 4,
    parameter int NUM_LANES    = 3,
    parameter int ROW_W        = 4,
    parameter int ROAD_ROWS    = 16,
    parameter int SPAWN_PERIOD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    obstacle_spawner_if.slave    spawnBus
);

    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROAD_ROWS - 1);
    localparam logic [1:0]       TOP_LANE   = 2'(NUM_LANES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                     state_q,       state_d;
    logic [CNT_W-1:0]           spawnCnt_q,    spawnCnt_d;
    logic [1:0]                 lastLane_q,    lastLane_d;
    logic [NUM_SLOTS-1:0]       valid_q,       valid_d;
    logic [2*NUM_SLOTS-1:0]     lane_q,        lane_d;
    logic [ROW_W*NUM_SLOTS-1:0] row_q,         row_d;
    logic                       spawnPulse_q,  spawnPulse_d;
    logic                       spawnDrop_q,   spawnDrop_d;
    logic [3:0]                 passedCount_q, passedCount_d;

    logic [1:0] candLane;
    logic [1:0] chosenLane;
    logic       slotFound;

    // Lane choice from the random byte. A candidate equal to the previous
    // spawn's lane is bumped to the next lane (wrapping) so two consecutive
    // obstacles never share a lane.
    always_comb begin
        candLane   = 2'(spawnBus.rand_in % 8'(NUM_LANES));
        chosenLane = candLane;
        if (candLane == lastLane_q) begin
            chosenLane = (candLane == TOP_LANE) ? 2'd0 : candLane + 2'd1;
        end
    end

    // Next-state logic. A tick first moves and retires obstacles, then the
    // spawn counter decides whether to allocate; allocation searches the
    // post-retire pool so a slot emptied on this tick can be reused at once.
    always_comb begin
        state_d       = state_q;
        spawnCnt_d    = spawnCnt_q;
        lastLane_d    = lastLane_q;
        valid_d       = valid_q;
        lane_d        = lane_q;
        row_d         = row_q;
        spawnPulse_d  = 1'b0;
        spawnDrop_d   = 1'b0;
        passedCount_d = 4'd0;
        slotFound     = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = '0;
                lane_d  = '0;
                row_d   = '0;
                if (spawnBus.enable) begin
                    state_d    = RUN;
                    spawnCnt_d = CNT_RELOAD;
                end
            end

            RUN: begin
                if (!spawnBus.enable) begin
                    state_d = IDLE;
                    valid_d = '0;
                    lane_d  = '0;
                    row_d   = '0;
                end else if (spawnBus.tick) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (valid_q[i]) begin
                            if (row_q[i*ROW_W +: ROW_W] == LAST_ROW) begin
                                valid_d[i]              = 1'b0;
                                row_d[i*ROW_W +: ROW_W] = '0;
                                lane_d[2*i +: 2]        = 2'd0;
                                passedCount_d           = passedCount_d + 4'd1;
                            end else begin
                                row_d[i*ROW_W +: ROW_W] = row_q[i*ROW_W +: ROW_W] + ROW_W'(1);
                            end
                        end
                    end

                    if (spawnCnt_q != '0) begin
                        spawnCnt_d = spawnCnt_q - CNT_W'(1);
                    end else begin
                        spawnCnt_d = CNT_RELOAD;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (!slotFound && !valid_d[i]) begin
                                slotFound               = 1'b1;
                                valid_d[i]              = 1'b1;
                                row_d[i*ROW_W +: ROW_W] = '0;
                                lane_d[2*i +: 2]        = chosenLane;
                            end
                        end
                        if (slotFound) begin
                            lastLane_d   = chosenLane;
                            spawnPulse_d = 1'b1;
                        end else begin
                            spawnDrop_d  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset returns everything to an empty idle
    // road with the spawn counter at its reload value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            spawnCnt_q    <= CNT_RELOAD;
            lastLane_q    <= 2'd0;
            valid_q       <= '0;
            lane_q        <= '0;
            row_q         <= '0;
            spawnPulse_q  <= 1'b0;
            spawnDrop_q   <= 1'b0;
            passedCount_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            spawnCnt_q    <= spawnCnt_d;
            lastLane_q    <= lastLane_d;
            valid_q       <= valid_d;
            lane_q        <= lane_d;
            row_q         <= row_d;
            spawnPulse_q  <= spawnPulse_d;
            spawnDrop_q   <= spawnDrop_d;
            passedCount_q <= passedCount_d;
        end
    end

    assign spawnBus.obs_valid    = valid_q;
    assign spawnBus.obs_lane     = lane_q;
    assign spawnBus.obs_row      = row_q;
    assign spawnBus.spawn_pulse  = spawnPulse_q;
    assign spawnBus.spawn_drop   = spawnDrop_q;
    assign spawnBus.passed_count = passedCount_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// ---------------------------------------------------------------------------
// tb_obstacle_spawner
// Randomised bench for obstacle_spawner. A behavioural model of the obstacle
// pool predicts the registered outputs for every clock; predictions are
// queued when inputs are driven and a separate monitor pops and compares
// them after each rising edge. A short spawn period is used so the pool
// fills up (drops) and retiring obstacles are reused on the same tick.
// ---------------------------------------------------------------------------
module tb_obstacle_spawner;

    localparam int NUM_SLOTS    = 4;
    localparam int NUM_LANES    = 3;
    localparam int ROW_W        = 4;
    localparam int ROAD_ROWS    = 16;
    localparam int SPAWN_PERIOD = 2;

    typedef struct packed {
        logic [NUM_SLOTS-1:0]       valid;
        logic [2*NUM_SLOTS-1:0]     lane;
        logic [ROW_W*NUM_SLOTS-1:0] row;
        logic                       pulse;
        logic                       drop;
        logic [3:0]                 passed;
    } expect_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    obstacle_spawner_if #(.NUM_SLOTS(NUM_SLOTS), .ROW_W(ROW_W)) spawnBus ();

    obstacle_spawner #(
        .NUM_SLOTS   (NUM_SLOTS),
        .NUM_LANES   (NUM_LANES),
        .ROW_W       (ROW_W),
        .ROAD_ROWS   (ROAD_ROWS),
        .SPAWN_PERIOD(SPAWN_PERIOD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .spawnBus(spawnBus)
    );

    always #5 clk = ~clk;

    expect_t expectQ[$];
    int      compared   = 0;
    int      mismatched = 0;

    // Behavioural model of the obstacle pool
    bit mRunning;
    int mCnt;
    int mLast;
    bit mValid [NUM_SLOTS];
    int mRow   [NUM_SLOTS];
    int mLane  [NUM_SLOTS];
    bit mPulse;
    bit mDrop;
    int mPassed;

    function automatic void clearSlots();
        for (int i = 0; i < NUM_SLOTS; i++) begin
            mValid[i] = 0;
            mRow[i]   = 0;
            mLane[i]  = 0;
        end
    endfunction

    function automatic void modelReset();
        mRunning = 0;
        mCnt     = SPAWN_PERIOD - 1;
        mLast    = 0;
        mPulse   = 0;
        mDrop    = 0;
        mPassed  = 0;
        clearSlots();
    endfunction

    function automatic void modelStep(bit en, bit tk, int rnd);
        int cand;
        int lane;
        int slot;
        mPulse  = 0;
        mDrop   = 0;
        mPassed = 0;
        if (!mRunning) begin
            clearSlots();
            if (en) begin
                mRunning = 1;
                mCnt     = SPAWN_PERIOD - 1;
            end
        end else if (!en) begin
            mRunning = 0;
            clearSlots();
        end else if (tk) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (mValid[i]) begin
                    if (mRow[i] == ROAD_ROWS - 1) begin
                        mValid[i] = 0;
                        mRow[i]   = 0;
                        mLane[i]  = 0;
                        mPassed++;
                    end else begin
                        mRow[i]++;
                    end
                end
            end
            if (mCnt > 0) begin
                mCnt--;
            end else begin
                mCnt = SPAWN_PERIOD - 1;
                cand = rnd % NUM_LANES;
                lane = (cand == mLast) ? (cand + 1) % NUM_LANES : cand;
                slot = -1;
                for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                    if (!mValid[i]) slot = i;
                end
                if (slot >= 0) begin
                    mValid[slot] = 1;
                    mRow[slot]   = 0;
                    mLane[slot]  = lane;
                    mLast        = lane;
                    mPulse       = 1;
                end else begin
                    mDrop = 1;
                end
            end
        end
    endfunction

    function automatic expect_t modelSnapshot();
        expect_t e;
        e = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            e.valid[i]              = mValid[i];
            e.lane[2*i +: 2]        = 2'(mLane[i]);
            e.row[i*ROW_W +: ROW_W] = ROW_W'(mRow[i]);
        end
        e.pulse  = mPulse;
        e.drop   = mDrop;
        e.passed = 4'(mPassed);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, required %0h",
                     name, $time, actual, required);
        end
    endtask

    task automatic checkAll(input expect_t e);
        checkOutput("obs_valid",    32'(spawnBus.obs_valid),    32'(e.valid));
        checkOutput("obs_lane",     32'(spawnBus.obs_lane),     32'(e.lane));
        checkOutput("obs_row",      32'(spawnBus.obs_row),      32'(e.row));
        checkOutput("spawn_pulse",  32'(spawnBus.spawn_pulse),  32'(e.pulse));
        checkOutput("spawn_drop",   32'(spawnBus.spawn_drop),   32'(e.drop));
        checkOutput("passed_count", 32'(spawnBus.passed_count), 32'(e.passed));
    endtask

    // Drive one cycle of inputs on the falling edge and queue the outputs
    // expected after the following rising edge. A fresh reset assertion is
    // also checked immediately, since reset acts without a clock edge.
    task automatic applyStimulus(input bit rst, input bit en, input bit tk,
                                 input logic [7:0] rnd);
        bit rose;
        @(negedge clk);
        rose             = rst && !reset;
        reset            = rst;
        spawnBus.enable  = en;
        spawnBus.tick    = tk;
        spawnBus.rand_in = rnd;
        if (rst) begin
            modelReset();
            if (rose) begin
                #1;
                checkAll(modelSnapshot());
            end
        end else begin
            modelStep(en, tk, int'(rnd));
        end
        expectQ.push_back(modelSnapshot());
    endtask

    // Monitor: every rising edge retires exactly one queued prediction
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expectQ.size() > 0) begin
                e = expectQ.pop_front();
                checkAll(e);
            end
        end
    end

    initial begin
        spawnBus.enable  = 1'b0;
        spawnBus.tick    = 1'b0;
        spawnBus.rand_in = 8'h00;
        modelReset();

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        // Constant 0xFF byte, tick every cycle: exercises the lane bump rule,
        // pool exhaustion and reuse of slots retired on a spawn tick
        repeat (80) applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);

        // Random ticks and bytes with occasional enable drops
        for (int n = 0; n < 700; n++) begin
            applyStimulus(1'b0, ($urandom_range(0, 39) != 0),
                          ($urandom_range(0, 1) == 1), 8'($urandom));
        end

        // Fill the road, then reset asynchronously with obstacles live
        repeat (30) applyStimulus(1'b0, 1'b1, 1'b1, 8'($urandom));
        repeat (2)  applyStimulus(1'b1, 1'b1, 1'b1, 8'($urandom));

        // Disable while ticking, then re-enable with tick every cycle
        repeat (40) applyStimulus(1'b0, 1'b1, 1'b1, 8'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
        applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
        repeat (40) applyStimulus(1'b0, 1'b1, 1'b1, 8'($urandom));

        // Mostly-ticking random run to finish
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'b0, ($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        repeat (2) @(posedge clk);
        #2;
        checkOutput("scoreboard_drain", 32'(expectQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Consumes the 8-bit pseudo-random byte from the LFSR stage and turns it into falling obstacles for the racing game.
- Owns a fixed pool of obstacle slots. On each frame tick it advances every live obstacle one row down the road and periodically spawns a new one in a lane chosen from the random byte.
- Feeds the renderer and collision/score logic downstream with registered slot positions and event pulses.

Parameters:
- NUM_SLOTS, 4, number of concurrent obstacle slots (1..8).
- NUM_LANES, 3, number of road lanes (2..4); lane index is 2 bits.
- ROW_W, 4, width of the row coordinate.
- ROAD_ROWS, 16, rows on screen; last row is ROAD_ROWS-1; must be <= 2**ROW_W.
- SPAWN_PERIOD, 8, frame ticks between spawn attempts (>= 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  game running; low forces IDLE.
- tick  input  1  one-cycle frame-tick pulse.
- rand_in  input  8  random byte from the LFSR stage, sampled on tick cycles only.
- obs_valid  output  NUM_SLOTS  bit i = slot i live.
- obs_lane  output  2*NUM_SLOTS  slot i lane at bits [2i+1:2i].
- obs_row  output  ROW_W*NUM_SLOTS  slot i row at bits [ROW_W*i+ROW_W-1:ROW_W*i].
- spawn_pulse  output  1  one cycle, a spawn succeeded.
- spawn_drop  output  1  one cycle, a spawn attempt found no free slot.
- passed_count  output  4  number of obstacles that left the road on this tick; zero on all other cycles.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; obs_valid, obs_lane, obs_row = 0; spawn_pulse, spawn_drop, passed_count = 0; spawn_cnt = SPAWN_PERIOD-1; last_lane = 0.
- All outputs are registered. Effects of a tick on cycle N are visible on cycle N+1.
- State IDLE:
  - Slots are held cleared; tick is ignored.
  - enable=1 moves to RUN on the next edge and reloads spawn_cnt to SPAWN_PERIOD-1.
- State RUN:
  - enable=0 moves to IDLE on the next edge. In that same edge all slots clear and pulses go to 0. No tick processing occurs in that cycle, even if tick=1.
  - A tick with enable=1 processes these steps in order, all committed in one edge:
    1. Advance: every valid slot with row < ROAD_ROWS-1 increments row by 1.
    2. Free: every valid slot with row == ROAD_ROWS-1 clears valid, and its row and lane are zeroed. passed_count = number freed.
    3. Spawn counter: if spawn_cnt != 0, decrement it. If spawn_cnt == 0, reload it to SPAWN_PERIOD-1 and make a spawn attempt.
    4. Lane choice: cand = rand_in mod NUM_LANES. If cand == last_lane, lane = (cand+1) mod NUM_LANES, otherwise lane = cand. This rule prevents two consecutive spawns in the same lane.
    5. Allocate: take the lowest-index slot that is free after step 2, so a slot freed on this tick is reusable. Set valid=1, row=0, lane=chosen, last_lane=chosen, spawn_pulse=1. A newly spawned obstacle does not advance on its spawn tick.
    6. No free slot: spawn_drop=1; last_lane is unchanged; the counter still reloads.
- Non-tick cycles: no slot changes; spawn_pulse, spawn_drop and passed_count return to 0.
- Reset mid-operation: immediately returns to the reset values (asynchronous), regardless of state.
- Width rules:
  - Row arithmetic never wraps, because step 2 removes a slot before it would exceed ROAD_ROWS-1.
  - Modulo is unsigned over the full 8 bits.

Test Plan:
- Reset check: assert reset mid-RUN with 2 live slots -> all outputs read 0 in the same cycle; after release with enable=1, state is RUN and spawn_cnt = SPAWN_PERIOD-1.
- Lane selection, SPAWN_PERIOD=4, rand_in=8'hFF held, enable=1:
  - 4th tick: 255 mod 3 = 0 equals last_lane=0, so slot0 gets lane=1, row=0, and spawn_pulse=1 one cycle later.
  - 8th tick: cand=0 differs from last_lane=1, so slot1 gets lane=0.
- Pass-through: a slot at row 15 with ROAD_ROWS=16 plus one tick -> obs_valid bit clears and passed_count=1 for exactly one cycle. Two slots at row 15 -> passed_count=2.
- Pool full: all 4 slots valid at rows 1..4, spawn tick -> spawn_drop=1, spawn_pulse=0, positions advance to 2..5, last_lane unchanged.
- Free and spawn on the same tick: slot0 at row 15 with the other slots full on a spawn tick -> passed_count=1 and slot0 respawns at row 0 with spawn_pulse=1.
- Disable: enable dropped while tick=1 -> next cycle all slots cleared, no pulses, tick ignored. Re-enabling -> first spawn exactly SPAWN_PERIOD ticks later.
